// File: rtl/bcd_display_converter_if.sv
// rtl/bcd_display_converter_if.sv - input handshake and display result bundle for the BCD converter
interface bcd_display_converter_if #(
  parameter int IN_WIDTH   = 20,
  parameter int NUM_DIGITS = 6
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_WIDTH-1:0]     in_value;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    out_valid;
  logic                    overflow;

  modport master (
    output in_valid, in_value,
    input  in_ready, digits, blank, out_valid, overflow
  );

  modport slave (
    input  in_valid, in_value,
    output in_ready, digits, blank, out_valid, overflow
  );
endinterface

// File: rtl/bcd_display_converter.sv
// rtl/bcd_display_converter.sv - sequential double-dabble binary-to-BCD converter with leading-zero blanking
module bcd_display_converter #(
  parameter int IN_WIDTH   = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bcd_display_converter_if.slave bus
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic logic [63:0] sat_value(input int n);
    logic [63:0] s;
    s = 64'd1;
    for (int i = 0; i < n; i++) s = s * 64'd10;
    return s - 64'd1;
  endfunction

  localparam logic [63:0] SAT64    = sat_value(NUM_DIGITS);
  // Saturation only matters when SAT is representable in the input width.
  localparam bit          SAT_FITS = ((SAT64 >> IN_WIDTH) == 64'd0);
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]   bin_q, bin_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  ovf_r_q, ovf_r_d;
  logic [BW-1:0]         digits_q, digits_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;

  logic [BW-1:0]         bcd_adj;
  logic [NUM_DIGITS-1:0] blank_new;
  logic                  zero_run;
  logic                  in_over;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Digit k blanks only when it and every digit above it are zero.
  always_comb begin
    blank_new = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run & (bcd_q[4*k +: 4] == 4'd0);
      blank_new[k] = zero_run;
    end
  end

  assign in_over = SAT_FITS && (64'(bus.in_value) > SAT64);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    ovf_r_d     = ovf_r_q;
    digits_d    = digits_q;
    blank_d     = blank_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d   = in_over ? SAT64[IN_WIDTH-1:0] : bus.in_value;
          ovf_r_d = in_over;
          bcd_d   = '0;
          cnt_d   = CW'(IN_WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BW-2:0], bin_q[IN_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        digits_d    = bcd_q;
        blank_d     = blank_new;
        overflow_d  = ovf_r_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      ovf_r_q     <= 1'b0;
      digits_q    <= '0;
      blank_q     <= BLANK_RST;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      ovf_r_q     <= ovf_r_d;
      digits_q    <= digits_d;
      blank_q     <= blank_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.digits    = digits_q;
  assign bus.blank     = blank_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_bcd_display_converter.sv
// tb/tb_bcd_display_converter.sv - directed bench for the BCD display converter
module tb_bcd_display_converter;
  logic clk = 1'b0;
  logic reset_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  bcd_display_converter_if #(.IN_WIDTH(20), .NUM_DIGITS(6)) bus ();

  bcd_display_converter #(.IN_WIDTH(20), .NUM_DIGITS(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [19:0] v, output logic [23:0] d, output logic [5:0] b,
                       output logic o);
    int  x;
    bit  seen;
    o = (v > 20'd999999);
    x = o ? 999999 : int'(v);
    for (int k = 0; k < 6; k++) begin
      d[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    seen = 1'b0;
    for (int k = 5; k >= 1; k--) begin
      if (d[4*k +: 4] != 4'd0) seen = 1'b1;
      b[k] = !seen;
    end
    b[0] = 1'b0;
  endtask

  // poke_at >= 0 pulses in_valid with 555 that many cycles into the conversion.
  task automatic conv_expect(input string tag, input logic [19:0] v, input logic [23:0] ed,
                             input logic [5:0] eb, input logic eo, input int poke_at);
    int n;
    int lat;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b1;
    bus.in_value = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (lat == poke_at) begin
        bus.in_valid = 1'b1;
        bus.in_value = 20'd555;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    bus.in_valid = 1'b0;
    check_eq({tag, "_lat"}, 32'(lat), 32'd21);
    check_eq({tag, "_digits"}, 32'(bus.digits), 32'(ed));
    check_eq({tag, "_blank"}, 32'(bus.blank), 32'(eb));
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
    check_eq({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    check_eq({tag, "_pulse1"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          first, second, pulses;
    logic [23:0] d1, d2, md;
    logic [5:0]  mb;
    logic        mo;
    logic [19:0] rv;

    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_digits", 32'(bus.digits), 32'h0);
    check_eq("rst_blank", 32'(bus.blank), 32'b111110);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    conv_expect("zero", 20'd0, 24'h000000, 6'b111110, 1'b0, -1);
    conv_expect("v123456", 20'd123456, 24'h123456, 6'b000000, 1'b0, -1);
    conv_expect("v42", 20'd42, 24'h000042, 6'b111100, 1'b0, -1);
    conv_expect("v999999", 20'd999999, 24'h999999, 6'b000000, 1'b0, -1);
    conv_expect("v1000000", 20'd1000000, 24'h999999, 6'b000000, 1'b1, -1);
    conv_expect("vmax", 20'hFFFFF, 24'h999999, 6'b000000, 1'b1, -1);
    conv_expect("v100000", 20'd100000, 24'h100000, 6'b000000, 1'b0, -1);
    conv_expect("v9", 20'd9, 24'h000009, 6'b111110, 1'b0, -1);
    conv_expect("poke", 20'd42, 24'h000042, 6'b111100, 1'b0, 5);

    // in_valid held high: 7 accepted first, 8 exactly 22 cycles later
    bus.in_valid = 1'b1;
    bus.in_value = 20'd7;
    @(posedge clk); #1;
    bus.in_value = 20'd8;
    first = -1; second = -1; pulses = 0; d1 = '0; d2 = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 22) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        pulses++;
        if (first < 0) begin
          first = cyc; d1 = bus.digits;
        end else if (second < 0) begin
          second = cyc; d2 = bus.digits;
        end
      end
    end
    check_eq("b2b_first_at", 32'(first), 32'd21);
    check_eq("b2b_second_at", 32'(second), 32'd43);
    check_eq("b2b_first_val", 32'(d1), 32'h000007);
    check_eq("b2b_second_val", 32'(d2), 32'h000008);
    check_eq("b2b_pulses", 32'(pulses), 32'd2);

    // Reset mid-conversion after an overflowing result is on display
    conv_expect("pre_rst", 20'd1048575, 24'h999999, 6'b000000, 1'b1, -1);
    bus.in_valid = 1'b1;
    bus.in_value = 20'd123;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_digits", 32'(bus.digits), 32'h0);
    check_eq("mid_rst_blank", 32'(bus.blank), 32'b111110);
    check_eq("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    check_eq("mid_rst_nopulse", 32'(pulses), 32'd0);

    for (int i = 0; i < 20; i++) begin
      rv = 20'($urandom_range(0, 20'hFFFFF));
      model(rv, md, mb, mo);
      conv_expect("rand", rv, md, mb, mo, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
